// File: rtl/ahb_arb_pkg.sv
`default_nettype none
// ============================================================================
// ahb_arb_pkg: arbiter state type, AHB HTRANS/HRESP encodings, one-hot helper.
// Rev 1.0
// ============================================================================
package ahb_arb_pkg;

   typedef enum logic [1:0] {
      DFLT = 2'd0,
      OWN  = 2'd1,
      LOCK = 2'd2
   } arb_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;
   localparam logic [1:0] HRESP_RETRY   = 2'b10;
   localparam logic [1:0] HRESP_SPLIT   = 2'b11;

   // OR-reduction encoder; only meaningful for a one-hot input.
   function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_pick.sv
`default_nettype none
// ============================================================================
// ahb_rr_pick: rotate-priority find-first, searching upward from ptr+1 with wrap.
// Rev 1.0
// ============================================================================
module ahb_rr_pick #(
   parameter int NUM_MASTERS = 16
) (
   input  logic [15:0] req,
   input  logic [3:0]  ptr,
   output logic [3:0]  idx,
   output logic        valid
);

   logic [3:0] cand;

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      // Offset NUM_MASTERS lands back on ptr itself, so it is searched last.
      for (int off = 1; off <= NUM_MASTERS; off++) begin
         cand = 4'((int'(ptr) + off) % NUM_MASTERS);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ahb_quota_arbiter.sv
`default_nettype none
// ============================================================================
// ahb_quota_arbiter: round-robin AHB arbiter with per-tenure beat quota and HLOCK.
// Split tracking enabled by defining AHB_QUOTA_ARB_SPLIT_EN.  Rev 1.0
// ============================================================================
module ahb_quota_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 16,
   parameter int QUOTA          = 8,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [15:0] HBUSREQx,
   input  logic [15:0] HLOCKx,
   input  logic [1:0]  HTRANS,
   input  logic        HREADY,
   input  logic [1:0]  HRESP,
   input  logic [15:0] HSPLIT,
   output logic [15:0] HGRANTx,
   output logic [3:0]  HMASTER,
   output logic        HMASTLOCK
);

   localparam logic [15:0] MASTER_MASK = (NUM_MASTERS >= 16) ? 16'hFFFF
                                       : 16'((32'd1 << NUM_MASTERS) - 32'd1);
   localparam logic [3:0]  DEF_IDX     = 4'(DEFAULT_MASTER);
   localparam logic [7:0]  QUOTA_MAX   = 8'(QUOTA);

   arb_state_e  state, state_nxt;
   logic [3:0]  grant_idx, grant_nxt;
   logic [3:0]  rr_ptr, ptr_nxt;
   logic [7:0]  beat_cnt, beat_nxt;
   logic [15:0] split_mask;
   logic [15:0] valid_req, pick_req;
   logic [3:0]  pick_idx;
   logic        pick_valid;
   logic        owner_masked, arb_point, beat_hit;

   assign HGRANTx = 16'(1) << grant_idx;

`ifdef AHB_QUOTA_ARB_SPLIT_EN
   logic [15:0] split_set;

   always_comb begin
      split_set = '0;
      if (!HREADY && HRESP == HRESP_SPLIT) split_set[HMASTER] = 1'b1;
   end

   // Release wins over a same-cycle SPLIT response.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) split_mask <= '0;
      else          split_mask <= (split_mask | split_set) & ~HSPLIT & MASTER_MASK;
   end
`else
   logic unused_split_inputs;
   assign unused_split_inputs = ^{HRESP, HSPLIT};
   assign split_mask          = '0;
`endif

   always_comb begin
      valid_req = HBUSREQx & MASTER_MASK & ~split_mask;
      pick_req  = valid_req;
      // The owner is a candidate again only if nobody else is asking.
      if (state != DFLT) pick_req[grant_idx] = 1'b0;
   end

   ahb_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_pick (
      .req   (pick_req),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign owner_masked = (state != DFLT) && split_mask[grant_idx];
   assign arb_point    = HREADY && (owner_masked ||
                         (state != LOCK && (state == DFLT || !valid_req[grant_idx] ||
                                            beat_cnt == QUOTA_MAX)));
   assign beat_hit     = (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) &&
                         (HMASTER == grant_idx) && (beat_cnt != QUOTA_MAX);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_idx;
      ptr_nxt   = rr_ptr;
      beat_nxt  = beat_cnt;
      if (HREADY) begin
         if (beat_hit) beat_nxt = beat_cnt + 8'd1;
         if (arb_point) begin
            beat_nxt = '0;
            if (pick_valid) begin
               grant_nxt = pick_idx;
               ptr_nxt   = pick_idx;
               state_nxt = HLOCKx[pick_idx] ? LOCK : OWN;
            end else if (state != DFLT && valid_req[grant_idx]) begin
               ptr_nxt   = grant_idx;
               state_nxt = HLOCKx[grant_idx] ? LOCK : OWN;
            end else begin
               grant_nxt = DEF_IDX;
               state_nxt = DFLT;
            end
         end else if (state == LOCK && !HLOCKx[grant_idx]) begin
            // Lock released: one more edge for the final locked data phase.
            state_nxt = OWN;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= DFLT;
         grant_idx <= DEF_IDX;
         rr_ptr    <= DEF_IDX;
         beat_cnt  <= '0;
         HMASTER   <= DEF_IDX;
         HMASTLOCK <= 1'b0;
      end else begin
         state     <= state_nxt;
         grant_idx <= grant_nxt;
         rr_ptr    <= ptr_nxt;
         beat_cnt  <= beat_nxt;
         if (HREADY) begin
            HMASTER   <= onehot2idx(HGRANTx);
            HMASTLOCK <= (state == LOCK);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ahb_quota_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ahb_quota_arbiter: directed self-checking bench for ahb_quota_arbiter.
// Rev 1.0
// ============================================================================
module tb_ahb_quota_arbiter;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [15:0] HBUSREQx;
   logic [15:0] HLOCKx;
   logic [1:0]  HTRANS;
   logic        HREADY;
   logic [1:0]  HRESP;
   logic [15:0] HSPLIT;
   logic [15:0] HGRANTx;
   logic [3:0]  HMASTER;
   logic        HMASTLOCK;

   int tests = 0;
   int fails = 0;

   always #5 HCLK = ~HCLK;

   ahb_quota_arbiter #(
      .NUM_MASTERS    (16),
      .QUOTA          (8),
      .DEFAULT_MASTER (0)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HBUSREQx  (HBUSREQx),
      .HLOCKx    (HLOCKx),
      .HTRANS    (HTRANS),
      .HREADY    (HREADY),
      .HRESP     (HRESP),
      .HSPLIT    (HSPLIT),
      .HGRANTx   (HGRANTx),
      .HMASTER   (HMASTER),
      .HMASTLOCK (HMASTLOCK)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bus(input string tag, input int g, input int m, input logic l);
      check({tag, ".grant"},  HGRANTx,            16'(1) << g);
      check({tag, ".master"}, {12'd0, HMASTER},   16'(m));
      check({tag, ".lock"},   {15'd0, HMASTLOCK}, {15'd0, l});
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle_inputs();
      HBUSREQx = '0;
      HLOCKx   = '0;
      HTRANS   = 2'b00;
      HREADY   = 1'b1;
      HRESP    = 2'b00;
      HSPLIT   = '0;
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      idle_inputs();
      #2;
      @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   // QUOTA 8, SEQ every cycle: 1 handover edge + 1 HMASTER edge + 8 beats = 10 edges per tenure.
   function automatic int rr_grant(input int n);
      if (n == 0) return 0;
      return (((n - 1) / 10) % 2 == 0) ? 3 : 7;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state, idle bus held for 10 cycles
      HRESETn = 1'b0;
      idle_inputs();
      #1;
      check_bus("rst", 0, 0, 1'b0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step();
         check_bus($sformatf("idle%0d", n), 0, 0, 1'b0);
      end

      // ---- masters 3 and 7 alternate on quota
      do_reset();
      HBUSREQx = 16'h0088;
      HTRANS   = 2'b11;
      for (int n = 1; n <= 40; n++) begin
         step();
         check_bus($sformatf("rr%0d", n), rr_grant(n), rr_grant(n - 1), 1'b0);
      end

      // ---- locked burst by master 5 while master 2 waits
      do_reset();
      HBUSREQx = 16'h0020;
      HLOCKx   = 16'h0020;
      HTRANS   = 2'b11;
      step();
      check_bus("lock1", 5, 0, 1'b0);
      HBUSREQx = 16'h0024;
      for (int n = 2; n <= 21; n++) begin
         step();
         check_bus($sformatf("lock%0d", n), 5, 5, 1'b1);
      end
      HLOCKx   = 16'h0000;
      HBUSREQx = 16'h0004;
      step();
      check_bus("unlock_hold", 5, 5, 1'b1);
      step();
      check_bus("unlock_move", 2, 5, 1'b0);
      step();
      check_bus("unlock_master", 2, 2, 1'b0);

      // ---- HREADY low freezes grant and HMASTER
      do_reset();
      HBUSREQx = 16'h0200;
      HTRANS   = 2'b10;
      step();
      check_bus("wait_g", 9, 0, 1'b0);
      step();
      check_bus("wait_m", 9, 9, 1'b0);
      HBUSREQx = 16'h0002;
      HREADY   = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         step();
         check_bus($sformatf("wait%0d", n), 9, 9, 1'b0);
      end
      HREADY = 1'b1;
      step();
      check_bus("wait_rel", 1, 9, 1'b0);
      step();
      check_bus("wait_rel_m", 1, 1, 1'b0);

      // ---- reset mid-burst, owner 4 with 6 beats counted
      do_reset();
      HBUSREQx = 16'h0010;
      HTRANS   = 2'b11;
      for (int n = 1; n <= 8; n++) step();
      check_bus("burst4", 4, 4, 1'b0);
      #2;
      HRESETn = 1'b0;
      #1;
      check_bus("rst_mid", 0, 0, 1'b0);
      HBUSREQx = 16'h0030;
      @(negedge HCLK);
      HRESETn = 1'b1;
      step();
      check_bus("rst_rearb", 4, 0, 1'b0);
      step();
      check_bus("rst_rearb_m", 4, 4, 1'b0);

`ifdef AHB_QUOTA_ARB_SPLIT_EN
      // ---- SPLIT on owner 6, master 10 takes over, HSPLIT releases 6
      do_reset();
      HBUSREQx = 16'h0040;
      HTRANS   = 2'b11;
      step();
      check_bus("split1", 6, 0, 1'b0);
      step();
      check_bus("split2", 6, 6, 1'b0);
      HBUSREQx = 16'h0440;
      HREADY   = 1'b0;
      HRESP    = 2'b11;
      step();
      check_bus("split3", 6, 6, 1'b0);
      HREADY = 1'b1;
      HRESP  = 2'b00;
      step();
      check_bus("split4", 10, 6, 1'b0);
      HSPLIT = 16'h0040;
      step();
      check_bus("split5", 10, 10, 1'b0);
      HSPLIT = 16'h0000;
      for (int n = 6; n <= 13; n++) begin
         step();
         check_bus($sformatf("split%0d", n), 10, 10, 1'b0);
      end
      step();
      check_bus("split14", 6, 10, 1'b0);
      step();
      check_bus("split15", 6, 6, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ahb_quota_arbiter.md
Name: ahb_quota_arbiter

Overview:
- AHB bus arbiter for up to 16 masters: round-robin, with a per-tenure beat quota so that long bursts cannot starve other requesters.
- Honours HLOCKx locked sequences and drives the HMASTER/HMASTLOCK address-phase pipeline.
- Sits between the master request lines and the address/data muxes of the shared AHB bus.
- Drop-in alternative to the fixed-priority arbiter; identical bus-side port set, plus HTRANS/HRESP for beat and split tracking.

Parameters:
- NUM_MASTERS, 16, number of requesters (2..16); unused HBUSREQx bits are ignored.
- QUOTA, 8, maximum NONSEQ/SEQ beats per tenure before forced re-arbitration (1..255).
- DEFAULT_MASTER, 0, index granted when no valid request exists.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HBUSREQx  in  16  per-master bus request.
- HLOCKx  in  16  per-master locked-transfer request.
- HTRANS  in  2  current address-phase transfer type.
- HREADY  in  1  transfer complete / bus handover enable.
- HRESP  in  2  slave response (used only with split feature).
- HSPLIT  in  16  split-release bits from slaves.
- HGRANTx  out  16  one-hot grant.
- HMASTER  out  4  index of address-phase owner.
- HMASTLOCK  out  1  current address phase is locked.

Behaviour:
- Reset: HGRANTx = 1<<DEFAULT_MASTER, HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, beat count = 0, RR pointer = DEFAULT_MASTER, state DFLT, split mask = 0.
- Invariants:
  - HGRANTx is always exactly one-hot, never zero.
  - Grant, HMASTER, HMASTLOCK and beat count change only on posedges where HREADY = 1.
- States:
  - DFLT: default master holds the grant, no valid request.
  - OWN: requester holds the grant, unlocked.
  - LOCK: owner holds the grant with HLOCKx set.
- Arbitration point: posedge with HREADY = 1 and state not LOCK, and any of:
  - owner's HBUSREQx = 0;
  - beat count == QUOTA;
  - state DFLT.
- Winner selection: first valid requester searching from RR pointer+1 upward, wrapping at NUM_MASTERS-1.
  - Valid = HBUSREQx set, index < NUM_MASTERS, and not split-masked.
  - The current owner may re-win only if no other valid requester exists; its beat count then restarts at 0.
  - No valid requester: grant DEFAULT_MASTER, go to DFLT.
- On winner change: RR pointer <= winner index, beat count <= 0; next state OWN, or LOCK if HLOCKx[winner].
- Beat count: increments on posedge with HREADY = 1, HTRANS[1] = 1 (NONSEQ/SEQ) and HMASTER == granted index; saturates at QUOTA.
- LOCK:
  - Quota is ignored; the grant is held while HLOCKx[owner] = 1.
  - When HLOCKx[owner] drops, hold one further HREADY cycle (last locked data phase), then behave as OWN.
- HMASTER pipeline:
  - On HREADY = 1 posedge, HMASTER <= index of the HGRANTx value before that edge.
  - HMASTLOCK <= (state == LOCK) on the same edge.
  - Handover latency: request to HGRANTx takes 1 HREADY edge; grant to HMASTER takes 1 further HREADY edge.
- HREADY = 0: all state frozen; request changes are not sampled.
- Simultaneous owner request drop and quota exhaustion: single re-arbitration, no double pointer advance.
- Reset asserted mid-burst: immediate return to reset values; no pending state retained.

Optional Feature:
- Macro: AHB_QUOTA_ARB_SPLIT_EN.
- With the macro defined:
  - A posedge with HREADY = 0 and HRESP = 2'b11 (SPLIT) sets split_mask[HMASTER].
  - HSPLIT[i] clears split_mask[i] on the next posedge; set and clear in the same cycle resolve to clear.
  - Masked masters are excluded from arbitration.
  - If the owner becomes masked, arbitration happens at the next HREADY edge regardless of LOCK.
- Without the macro: HRESP and HSPLIT are ignored; split_mask is constant 0.

Decomposition:
- Package ahb_arb_pkg:
  - arb_state_e {DFLT, OWN, LOCK};
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
  - HRESP encodings (OKAY, ERROR, RETRY, SPLIT);
  - function onehot2idx.
- Sub-module ahb_rr_pick: combinational rotate-priority find-first (request vector, pointer -> winner index, valid).

Test Plan:
- Reset only, no requests -> HGRANTx = 16'h0001, HMASTER = 0, HMASTLOCK = 0, held for 10 cycles.
- Masters 3 and 7 request continuously, HTRANS = SEQ, HREADY = 1, QUOTA = 8 -> grant alternates 3 / 7 every 8 beats; HMASTER follows grant one edge later.
- Master 5 requests with HLOCKx[5] = 1 for 20 beats while master 2 requests -> grant stays on 5 and HMASTLOCK = 1 throughout; grant moves to 2 one HREADY edge after HLOCKx[5] falls.
- Master 9 granted, HREADY held low 5 cycles while master 1 requests -> HGRANTx and HMASTER are unchanged until HREADY returns.
- HRESETn pulsed low mid-burst (owner 4, beat count 6) -> outputs immediately return to reset values; re-arbitration from pointer 0.
- SPLIT_EN: owner 6 receives SPLIT while master 10 requests -> grant to 10; HSPLIT[6] pulse -> 6 eligible again and wins next arbitration.
